// File: rtl/pipelined_logic_unit.sv
// Two-stage pipelined bitwise logic unit with valid/ready handshake on both sides,
// accumulate mode (B replaced by the previous result), zero/parity flags and a delivery counter.
module pipelined_logic_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] INPUT_A,
  input  logic [WIDTH-1:0] INPUT_B,
  input  logic [2:0]       OP,
  input  logic             ACC_MODE,
  input  logic             CLEAR_ACC,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUTPUT,
  output logic             ZERO,
  output logic             PARITY,
  output logic [CNT_W-1:0] OUT_COUNT
);

  function automatic logic [WIDTH-1:0] logic_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] r;
    case (op)
      3'b000:  r = a ^ b;
      3'b001:  r = ~(a | b);
      3'b010:  r = a | b;
      3'b011:  r = ~(a ^ b);
      3'b100:  r = a & b;
      3'b101:  r = ~(a & b);
      3'b110:  r = ~a;
      3'b111:  r = a;
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  function automatic logic parity_of(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  logic             s1_valid_r;
  logic [WIDTH-1:0] s1_data_r;
  logic [WIDTH-1:0] acc_r;

  logic             s2_en_s;
  logic             s1_en_s;
  logic             accept_s;
  logic             deliver_s;
  logic [2:0]       op_s;
  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] b_op_s;
  logic [WIDTH-1:0] result_s;

  // Pipeline enables and the stage-1 result; operands are gated by accept so idle X never reaches state
  always_comb begin
    s2_en_s   = !OUT_VALID || OUT_READY;
    s1_en_s   = !s1_valid_r || s2_en_s;
    IN_READY  = !RST_N || s1_en_s;
    accept_s  = IN_VALID && IN_READY;
    deliver_s = OUT_VALID && OUT_READY;
    if (accept_s) begin
      op_s   = OP;
      a_s    = INPUT_A;
      b_op_s = ACC_MODE ? acc_r : INPUT_B;
    end else begin
      op_s   = 3'b000;
      a_s    = {WIDTH{1'b0}};
      b_op_s = {WIDTH{1'b0}};
    end
    result_s = logic_op(op_s, a_s, b_op_s);
  end

  // Stage 1: capture the result on accept, drain to a bubble when it advances without one
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s1_valid_r <= 1'b0;
      s1_data_r  <= {WIDTH{1'b0}};
    end else if (s1_en_s) begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_data_r <= result_s;
      end else begin
        s1_data_r <= s1_data_r;
      end
    end else begin
      s1_valid_r <= s1_valid_r;
      s1_data_r  <= s1_data_r;
    end
  end

  // Accumulator: clear wins over an update in the same cycle (the op still saw the old value)
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      acc_r <= {WIDTH{1'b0}};
    end else if (CLEAR_ACC) begin
      acc_r <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      acc_r <= result_s;
    end else begin
      acc_r <= acc_r;
    end
  end

  // Stage 2: output register with flags; everything holds while the sink stalls
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      OUT_VALID <= 1'b0;
      OUTPUT    <= {WIDTH{1'b0}};
      ZERO      <= 1'b1;
      PARITY    <= 1'b0;
    end else if (s2_en_s) begin
      OUT_VALID <= s1_valid_r;
      OUTPUT    <= s1_data_r;
      ZERO      <= (s1_data_r == {WIDTH{1'b0}});
      PARITY    <= parity_of(s1_data_r);
    end else begin
      OUT_VALID <= OUT_VALID;
      OUTPUT    <= OUTPUT;
      ZERO      <= ZERO;
      PARITY    <= PARITY;
    end
  end

  // Delivered-result counter, wraps naturally
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      OUT_COUNT <= {CNT_W{1'b0}};
    end else if (deliver_s) begin
      OUT_COUNT <= OUT_COUNT + CNT_W'(1);
    end else begin
      OUT_COUNT <= OUT_COUNT;
    end
  end

endmodule

// File: tb/tb_pipelined_logic_unit.sv
// Self-checking bench for pipelined_logic_unit: a posedge monitor scores every delivery
// against a reference queue, and each scenario task adds its own inline checks.
module tb_pipelined_logic_unit;
  logic        CLK = 1'b0;
  logic        RST_N, IN_VALID, IN_READY, ACC_MODE, CLEAR_ACC;
  logic        OUT_VALID, OUT_READY, ZERO, PARITY;
  logic [15:0] INPUT_A, INPUT_B, OUTPUT;
  logic [2:0]  OP;
  logic [7:0]  OUT_COUNT;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          total_del = 0;
  logic [15:0] exp_q[$];
  logic [15:0] m_acc, mon_e, mon_b, mon_r;

  always #5 CLK = ~CLK;

  pipelined_logic_unit #(.WIDTH(16), .CNT_W(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .INPUT_A(INPUT_A), .INPUT_B(INPUT_B), .OP(OP), .ACC_MODE(ACC_MODE),
    .CLEAR_ACC(CLEAR_ACC), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUTPUT(OUTPUT), .ZERO(ZERO), .PARITY(PARITY), .OUT_COUNT(OUT_COUNT)
  );

  function automatic logic [15:0] model_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'd0: return a ^ b;
      3'd1: return ~(a | b);
      3'd2: return a | b;
      3'd3: return ~(a ^ b);
      3'd4: return a & b;
      3'd5: return ~(a & b);
      3'd6: return ~a;
      default: return a;
    endcase
  endfunction

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                       input logic accm, input logic clr);
    IN_VALID = 1'b1; INPUT_A = a; INPUT_B = b; OP = op; ACC_MODE = accm; CLEAR_ACC = clr;
  endtask

  task automatic idle(input logic clr);
    IN_VALID = 1'b0; INPUT_A = 16'hxxxx; INPUT_B = 16'hxxxx; OP = 3'bxxx; ACC_MODE = 1'bx;
    CLEAR_ACC = clr;
  endtask

  // Scoreboard: push the modelled result on accept, pop and compare on deliver
  always @(posedge CLK) begin
    if (!RST_N) begin
      exp_q.delete();
      m_acc = 16'h0000;
    end else begin
      if (OUT_VALID && OUT_READY) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL sb_extra got %h want none", OUTPUT);
        end else begin
          mon_e = exp_q.pop_front();
          if (OUTPUT !== mon_e || ZERO !== (mon_e == 16'h0000) || PARITY !== ^mon_e) begin
            n_bad++;
            $display("FAIL sb_result got %h/z%b/p%b want %h/z%b/p%b", OUTPUT, ZERO, PARITY,
                     mon_e, (mon_e == 16'h0000), ^mon_e);
          end
        end
      end
      if (IN_VALID && IN_READY) begin
        mon_b = ACC_MODE ? m_acc : INPUT_B;
        mon_r = model_op(OP, INPUT_A, mon_b);
        exp_q.push_back(mon_r);
        m_acc = mon_r;
      end
      if (CLEAR_ACC) m_acc = 16'h0000;
    end
  end

  task automatic test_reset;
    RST_N = 1'b0; OUT_READY = 1'b1; idle(1'b0);
    #1;
    n_cmp++; if (IN_READY !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready_during got %b want 1", IN_READY); end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    n_cmp++; if (OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b want 0", OUT_VALID); end
    n_cmp++; if (OUTPUT !== 16'h0000) begin n_bad++; $display("FAIL rst_output got %h want 0000", OUTPUT); end
    n_cmp++; if (ZERO !== 1'b1 || PARITY !== 1'b0) begin n_bad++; $display("FAIL rst_flags got z%b p%b want z1 p0", ZERO, PARITY); end
    n_cmp++; if (OUT_COUNT !== 8'h00) begin n_bad++; $display("FAIL rst_count got %h want 00", OUT_COUNT); end
    RST_N = 1'b1;
    @(posedge CLK); @(negedge CLK);
    n_cmp++; if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL rst_after got rdy%b vld%b want rdy1 vld0", IN_READY, OUT_VALID); end
  endtask

  task automatic test_all_ops;
    logic [15:0] tab [8];
    int acc_cyc [8];
    int i = 0;
    int j = 0;
    tab = '{16'h0FF0, 16'h000F, 16'hFFF0, 16'hF00F, 16'hF000, 16'h0FFF, 16'h0F0F, 16'hF0F0};
    OUT_READY = 1'b1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (i < 8) drive(16'hF0F0, 16'hFF00, 3'(i), 1'b0, 1'b0);
      else idle(1'b0);
      #1;
      if (OUT_VALID) begin
        n_cmp++;
        if (j >= 8 || OUTPUT !== tab[j] || ZERO !== 1'b0 || cyc != acc_cyc[j] + 2) begin
          n_bad++;
          $display("FAIL ops_result idx %0d got %h z%b at cyc %0d want %h z0 at cyc %0d", j, OUTPUT, ZERO, cyc,
                   (j < 8) ? tab[j] : 16'h0000, (j < 8) ? acc_cyc[j] + 2 : -1);
        end
        j++;
      end
      if (IN_VALID && IN_READY) begin acc_cyc[i] = cyc; i++; end
      @(posedge CLK); @(negedge CLK);
    end
    total_del += j;
    n_cmp++; if (j != 8) begin n_bad++; $display("FAIL ops_delivered got %0d want 8", j); end
    n_cmp++; if (OUT_COUNT !== 8'd8) begin n_bad++; $display("FAIL ops_count got %0d want 8", OUT_COUNT); end
  endtask

  task automatic test_accumulate;
    logic [15:0] a_in [5];
    logic [15:0] exp_v [5];
    logic        exp_p [5];
    logic        clr_in [5];
    int i = 0;
    int j = 0;
    a_in = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0001};
    exp_v = '{16'h0001, 16'h0003, 16'h0007, 16'h000F, 16'h0001};
    exp_p = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    clr_in = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    OUT_READY = 1'b1;
    idle(1'b1);
    @(posedge CLK); @(negedge CLK);
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (i < 5) drive(a_in[i], 16'hxxxx, 3'b000, 1'b1, clr_in[i]);
      else idle(1'b0);
      #1;
      if (OUT_VALID) begin
        n_cmp++;
        if (j >= 5 || OUTPUT !== exp_v[j] || PARITY !== exp_p[j]) begin
          n_bad++;
          $display("FAIL acc_result idx %0d got %h p%b want %h p%b", j, OUTPUT, PARITY,
                   (j < 5) ? exp_v[j] : 16'h0000, (j < 5) ? exp_p[j] : 1'b0);
        end
        j++;
      end
      if (IN_VALID && IN_READY) i++;
      @(posedge CLK); @(negedge CLK);
    end
    total_del += j;
    n_cmp++; if (j != 5) begin n_bad++; $display("FAIL acc_delivered got %0d want 5", j); end
  endtask

  task automatic test_backpressure;
    int idx = 0;
    int del = 0;
    logic [15:0] hold;
    OUT_READY = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (idx < 5) drive(16'hA000 + 16'(idx), 16'h0000, 3'b111, 1'b0, 1'b0);
      else idle(1'b0);
      #1;
      if (IN_VALID && IN_READY) idx++;
      @(posedge CLK); @(negedge CLK);
    end
    n_cmp++; if (idx != 2) begin n_bad++; $display("FAIL bp_accepted got %0d want 2", idx); end
    n_cmp++; if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1) begin n_bad++; $display("FAIL bp_stall got rdy%b vld%b want rdy0 vld1", IN_READY, OUT_VALID); end
    hold = OUTPUT;
    n_cmp++; if (hold !== 16'hA000) begin n_bad++; $display("FAIL bp_head got %h want a000", hold); end
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); @(negedge CLK);
      n_cmp++; if (OUTPUT !== 16'hA000 || OUT_VALID !== 1'b1) begin n_bad++; $display("FAIL bp_hold got %h vld%b want a000 vld1", OUTPUT, OUT_VALID); end
    end
    OUT_READY = 1'b1;
    for (int cyc = 0; cyc < 20 && del < 5; cyc++) begin
      if (idx < 5) drive(16'hA000 + 16'(idx), 16'h0000, 3'b111, 1'b0, 1'b0);
      else idle(1'b0);
      #1;
      if (OUT_VALID && OUT_READY) begin
        n_cmp++;
        if (OUTPUT !== 16'hA000 + 16'(del)) begin n_bad++; $display("FAIL bp_order got %h want %h", OUTPUT, 16'hA000 + 16'(del)); end
        del++;
      end
      if (IN_VALID && IN_READY) idx++;
      @(posedge CLK); @(negedge CLK);
    end
    idle(1'b0);
    total_del += del;
    n_cmp++; if (del != 5 || exp_q.size() != 0) begin n_bad++; $display("FAIL bp_drain got %0d delivered %0d pending want 5 and 0", del, exp_q.size()); end
  endtask

  task automatic test_zero_wrap;
    int need;
    int sent = 0;
    int del = 0;
    OUT_READY = 1'b1;
    drive(16'h1234, 16'h1234, 3'b000, 1'b0, 1'b0);
    @(posedge CLK); @(negedge CLK);
    idle(1'b0);
    @(posedge CLK); @(negedge CLK);
    n_cmp++; if (OUT_VALID !== 1'b1 || OUTPUT !== 16'h0000 || ZERO !== 1'b1 || PARITY !== 1'b0) begin
      n_bad++; $display("FAIL zero_result got vld%b %h z%b p%b want vld1 0000 z1 p0", OUT_VALID, OUTPUT, ZERO, PARITY);
    end
    @(posedge CLK); @(negedge CLK);
    total_del += 1;
    need = 256 - (total_del % 256);
    for (int cyc = 0; cyc < need * 5 + 50 && del < need; cyc++) begin
      if (sent < need) drive(16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);
      else idle(1'b0);
      OUT_READY = ($urandom_range(0, 3) != 0);
      #1;
      if (OUT_VALID && OUT_READY) del++;
      if (IN_VALID && IN_READY) sent++;
      @(posedge CLK); @(negedge CLK);
    end
    idle(1'b0); OUT_READY = 1'b1;
    total_del += del;
    n_cmp++; if (del != need) begin n_bad++; $display("FAIL wrap_timeout got %0d delivered want %0d", del, need); end
    n_cmp++; if (OUT_COUNT !== 8'h00) begin n_bad++; $display("FAIL wrap_count got %h want 00", OUT_COUNT); end
  endtask

  task automatic test_mid_reset;
    int idx = 0;
    int del = 0;
    OUT_READY = 1'b0;
    for (int cyc = 0; cyc < 6 && idx < 2; cyc++) begin
      drive(16'h00F0 + 16'(idx), 16'h0000, 3'b111, 1'b0, 1'b0);
      #1;
      if (IN_READY) idx++;
      @(posedge CLK); @(negedge CLK);
    end
    idle(1'b0);
    @(posedge CLK); @(negedge CLK);
    n_cmp++; if (OUT_VALID !== 1'b1 || IN_READY !== 1'b0) begin n_bad++; $display("FAIL mrst_full got vld%b rdy%b want vld1 rdy0", OUT_VALID, IN_READY); end
    RST_N = 1'b0;
    #1;
    n_cmp++; if (IN_READY !== 1'b1) begin n_bad++; $display("FAIL mrst_ready_during got %b want 1", IN_READY); end
    @(posedge CLK); @(negedge CLK);
    n_cmp++; if (OUT_VALID !== 1'b0 || OUT_COUNT !== 8'h00 || ZERO !== 1'b1) begin
      n_bad++; $display("FAIL mrst_state got vld%b cnt%h z%b want vld0 cnt00 z1", OUT_VALID, OUT_COUNT, ZERO);
    end
    RST_N = 1'b1; OUT_READY = 1'b1; total_del = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK); @(negedge CLK);
      n_cmp++; if (OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL mrst_stale got vld%b out %h want vld0", OUT_VALID, OUTPUT); end
    end
    drive(16'h0005, 16'hxxxx, 3'b000, 1'b1, 1'b0);
    @(posedge CLK); @(negedge CLK);
    idle(1'b0);
    for (int cyc = 0; cyc < 6 && del == 0; cyc++) begin
      #1;
      if (OUT_VALID) begin
        n_cmp++; if (OUTPUT !== 16'h0005) begin n_bad++; $display("FAIL mrst_acc got %h want 0005", OUTPUT); end
        del++;
      end
      @(posedge CLK); @(negedge CLK);
    end
    n_cmp++; if (del != 1 || OUT_COUNT !== 8'd1) begin n_bad++; $display("FAIL mrst_deliver got %0d cnt %0d want 1 cnt 1", del, OUT_COUNT); end
  endtask

  initial begin
    test_reset();
    test_all_ops();
    test_accumulate();
    test_backpressure();
    test_zero_wrap();
    test_mid_reset();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL sb_leftover got %0d pending want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
